// File: rtl/vco_ctrl_pkg.sv
// Shared types and default widths for the VCO phase-count decimation controller.
package vco_ctrl_pkg;

    localparam int unsigned DEF_N_BITS   = 5;
    localparam int unsigned DEF_ACC_BITS = 16;
    localparam int unsigned DEF_WIN_BITS = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPrime = 2'd1,
        StAccum = 2'd2
    } state_e;

endpackage

// File: rtl/vco_phase_diff.sv
// Holds the previous phase sample and produces the unsigned modulo-2^N_BITS phase step.
module vco_phase_diff
    import vco_ctrl_pkg::*;
#(
    parameter int unsigned N_BITS = DEF_N_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] sample,
    input  logic              load,
    input  logic              enable,
    output logic [N_BITS-1:0] delta
);

    logic [N_BITS-1:0] prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= '0;
        end else if (load || enable) begin
            prev_q <= sample;
        end
    end

    // Natural N_BITS wrap gives the counter-rollover-safe difference.
    assign delta = sample - prev_q;

endmodule

// File: rtl/vco_decim_ctrl.sv
// Windowed accumulation of VCO phase steps with a valid/ready result port and sticky overrun.
// Define VCO_DECIM_SAT_EN to saturate the accumulator instead of wrapping.
module vco_decim_ctrl
    import vco_ctrl_pkg::*;
#(
    parameter int unsigned N_BITS   = DEF_N_BITS,
    parameter int unsigned ACC_BITS = DEF_ACC_BITS,
    parameter int unsigned WIN_BITS = DEF_WIN_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_BITS-1:0]   sampled_binary,
    input  logic                run,
    input  logic [WIN_BITS-1:0] window_len,
    output logic [ACC_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                overrun,
    input  logic                clear_overrun
);

    state_e              state_q, state_d;
    logic [WIN_BITS-1:0] len_q, len_d;
    logic [WIN_BITS-1:0] cnt_q, cnt_d;
    logic [ACC_BITS-1:0] acc_q, acc_d;
    logic [ACC_BITS-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;

    logic                prime;
    logic                accum_en;
    logic                last;
    logic                drop;
    logic [N_BITS-1:0]   delta;
    logic [ACC_BITS-1:0] sum;

    assign prime    = (state_q == StPrime);
    assign accum_en = (state_q == StAccum);
    // A latched length of 0 wraps to all-ones here, i.e. a 2^WIN_BITS window.
    assign last     = accum_en && (cnt_q == (len_q - WIN_BITS'(1)));
    assign drop     = last && valid_q && !out_ready;

    vco_phase_diff #(
        .N_BITS (N_BITS)
    ) u_phase_diff (
        .clk    (clk),
        .reset  (reset),
        .sample (sampled_binary),
        .load   (prime),
        .enable (accum_en),
        .delta  (delta)
    );

`ifdef VCO_DECIM_SAT_EN
    localparam int unsigned SUM_BITS = ((ACC_BITS > N_BITS) ? ACC_BITS : N_BITS) + 1;
    logic [SUM_BITS-1:0] sum_full;

    assign sum_full = SUM_BITS'(acc_q) + SUM_BITS'(delta);
    assign sum      = (|sum_full[SUM_BITS-1:ACC_BITS]) ? '1 : sum_full[ACC_BITS-1:0];
`else
    assign sum = acc_q + ACC_BITS'(delta);
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        case (state_q)
            StIdle: begin
                if (run) begin
                    len_d   = window_len;
                    state_d = StPrime;
                end
            end
            StPrime: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = run ? StAccum : StIdle;
            end
            StAccum: begin
                if (last) begin
                    acc_d = '0;
                    cnt_d = '0;
                    len_d = window_len;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + WIN_BITS'(1);
                end
                if (!run) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A finishing window still delivers its result even if run drops on that cycle.
        if (last && !drop) begin
            data_d  = sum;
            valid_d = 1'b1;
        end else if (!last && valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (drop) begin
            ovr_d = 1'b1;
        end else if (clear_overrun) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_vco_decim_ctrl.sv
// Randomized and directed bench for vco_decim_ctrl against a window-sum reference model.
module tb_vco_decim_ctrl;

    localparam int unsigned NB  = 5;
    localparam int unsigned AB  = 16;
    localparam int unsigned WB  = 8;
    localparam int unsigned SAB = 4;
`ifdef VCO_DECIM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] sampled_binary;
    logic          run;
    logic [WB-1:0] window_len;
    logic          out_ready;
    logic          clear_overrun;
    logic [AB-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic          overrun;

    logic [NB-1:0]  s_sample;
    logic           s_run;
    logic [WB-1:0]  s_len;
    logic           s_ready;
    logic [SAB-1:0] s_data;
    logic           s_valid;
    logic           s_busy;
    logic           s_overrun;

    vco_decim_ctrl #(.N_BITS(NB), .ACC_BITS(AB), .WIN_BITS(WB)) dut (
        .clk            (clk),
        .reset          (reset),
        .sampled_binary (sampled_binary),
        .run            (run),
        .window_len     (window_len),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .overrun        (overrun),
        .clear_overrun  (clear_overrun)
    );

    vco_decim_ctrl #(.N_BITS(NB), .ACC_BITS(SAB), .WIN_BITS(WB)) dut_small (
        .clk            (clk),
        .reset          (reset),
        .sampled_binary (s_sample),
        .run            (s_run),
        .window_len     (s_len),
        .out_data       (s_data),
        .out_valid      (s_valid),
        .out_ready      (s_ready),
        .busy           (s_busy),
        .overrun        (s_overrun),
        .clear_overrun  (1'b0)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: 0 idle, 1 prime, 2 accumulating; window sum kept unbounded.
    int     m_mode;
    int     m_len;
    int     m_n;
    int     m_prev;
    longint m_total;
    bit     m_valid;
    bit     m_ovr;
    longint m_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint fold(input longint total, input int bits);
        longint maxv;
        maxv = (longint'(1) << bits) - 1;
        if (SAT) return (total > maxv) ? maxv : total;
        return total & maxv;
    endfunction

    function automatic int eff_len(input logic [WB-1:0] wl);
        return (wl == 0) ? (1 << WB) : int'(wl);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_len = 0; m_n = 0; m_prev = 0; m_total = 0;
        m_valid = 1'b0; m_ovr = 1'b0; m_data = 0;
    endtask

    task automatic model_step(input logic r, input logic [NB-1:0] s, input logic [WB-1:0] wl,
                              input logic rdy, input logic clr);
        bit     have;
        bit     dropped;
        longint res;
        have = 1'b0; dropped = 1'b0; res = 0;
        if (m_mode == 0) begin
            if (r) begin
                m_len  = eff_len(wl);
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (!r) m_mode = 0;
            else begin
                m_prev = int'(s); m_total = 0; m_n = 0; m_mode = 2;
            end
        end else begin
            m_total += (int'(s) - m_prev + (1 << NB)) % (1 << NB);
            m_prev = int'(s);
            m_n++;
            if (m_n == m_len) begin
                have = 1'b1;
                res = fold(m_total, AB);
                m_total = 0; m_n = 0; m_len = eff_len(wl);
            end
            if (!r) m_mode = 0;
        end
        if (have) begin
            if (!m_valid || rdy) begin
                m_data = res; m_valid = 1'b1;
            end else dropped = 1'b1;
        end else if (m_valid && rdy) m_valid = 1'b0;
        if (dropped) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    task automatic step();
        logic          r, rdy, clr;
        logic [NB-1:0] s;
        logic [WB-1:0] wl;
        r = run; rdy = out_ready; clr = clear_overrun; s = sampled_binary; wl = window_len;
        @(posedge clk);
        model_step(r, s, wl, rdy, clr);
        #1;
        check("out_valid", out_valid, m_valid);
        check("busy", busy, m_mode != 0);
        check("overrun", overrun, m_ovr);
        if (m_valid) check("out_data", out_data, m_data);
    endtask

    task automatic idle_drain();
        run = 1'b0; out_ready = 1'b1; clear_overrun = 1'b1;
        step();
        step();
        clear_overrun = 1'b0;
    endtask

    initial begin
        sampled_binary = '0; run = 1'b0; window_len = '0; out_ready = 1'b0;
        clear_overrun = 1'b0;
        s_sample = '0; s_run = 1'b0; s_len = 8'd2; s_ready = 1'b1;
        model_reset();
        #12;
        check("rst_data", out_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b1;

        // Idle after reset: nothing moves without run.
        for (int i = 0; i < 3; i++) begin
            sampled_binary = NB'($urandom); window_len = WB'($urandom);
            step();
            check("idle_data", out_data, 0);
        end

        // Narrow accumulator: two steps of 31 into a 4-bit result.
        s_run = 1'b1;
        step();
        s_sample = 5'd0;  step();
        s_sample = 5'd31; step();
        s_sample = 5'd30; step();
        check("sat_valid", s_valid, 1);
        check("sat_data", s_data, SAT ? 15 : 14);
        check("sat_busy", s_busy, 1);
        check("sat_overrun", s_overrun, 0);
        s_run = 1'b0;
        step();

        // Steady +3 ramp, window of 4.
        window_len = 8'd4; run = 1'b1; out_ready = 1'b1; sampled_binary = '0;
        step();
        step();
        for (int k = 1; k <= 8; k++) begin
            sampled_binary = NB'(3 * k);
            step();
            check("ramp_valid", out_valid, (k % 4) == 0);
            if ((k % 4) == 0) check("ramp_data", out_data, 12);
        end
        idle_drain();

        // Phase counter wrap 30 -> 2 with a single-sample window.
        window_len = 8'd1; run = 1'b1;
        step();
        sampled_binary = 5'd30; step();
        sampled_binary = 5'd2;  step();
        check("wrap_valid", out_valid, 1);
        check("wrap_data", out_data, 4);
        idle_drain();

        // Stalled consumer across two windows.
        window_len = 8'd2; run = 1'b1; out_ready = 1'b0;
        step();
        for (int k = 0; k <= 4; k++) begin
            sampled_binary = NB'(k);
            step();
        end
        check("stall_data", out_data, 2);
        check("stall_overrun", overrun, 1);
        run = 1'b0; clear_overrun = 1'b1;
        step();
        check("clr_overrun", overrun, 0);
        check("held_valid", out_valid, 1);
        check("held_data", out_data, 2);
        clear_overrun = 1'b0;
        idle_drain();

        // Abort after two samples, then a fresh window.
        window_len = 8'd4; run = 1'b1; out_ready = 1'b1;
        step();
        for (int k = 0; k <= 2; k++) begin
            sampled_binary = NB'(k);
            step();
        end
        run = 1'b0; sampled_binary = 5'd3;
        step();
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        run = 1'b1;
        step();
        check("restart_busy", busy, 1);
        for (int k = 5; k <= 9; k++) begin
            sampled_binary = NB'(k);
            step();
        end
        check("restart_data", out_data, 4);
        idle_drain();

        // window_len 0 means a 256-sample window.
        window_len = 8'd0; run = 1'b1;
        step();
        sampled_binary = '0;
        step();
        for (int k = 1; k <= 256; k++) begin
            sampled_binary = NB'(k);
            step();
            if (k == 255) check("len0_early", out_valid, 0);
        end
        check("len0_valid", out_valid, 1);
        check("len0_data", out_data, 256);
        idle_drain();

        // Asynchronous reset mid-window with a result pending.
        window_len = 8'd1; run = 1'b1; out_ready = 1'b0;
        step();
        sampled_binary = 5'd0; step();
        sampled_binary = 5'd7; step();
        sampled_binary = 5'd9; step();
        #3;
        reset = 1'b0;
        #1;
        check("arst_data", out_data, 0);
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_overrun", overrun, 0);
        model_reset();
        run = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
        check("post_rst_data", out_data, 0);

        // Random traffic.
        window_len = 8'd3;
        for (int i = 0; i < 3000; i++) begin
            sampled_binary = NB'($urandom);
            run            = ($urandom_range(255) != 0);
            if ($urandom_range(15) == 0) begin
                window_len = ($urandom_range(7) == 0) ? 8'd0 : WB'($urandom_range(7, 1));
            end
            out_ready     = ($urandom_range(3) != 0);
            clear_overrun = ($urandom_range(31) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
